// File: rtl/drv_conf_sequencer.sv
// Configuration-pulse sequencer: issues PUSH_COUNT pulses aligned to a column slot and gates position sync while busy.
// Define DRV_CONF_AUTOBOOT_EN to have one sequence pending straight out of reset.
module drv_conf_sequencer #(
   parameter int unsigned PUSH_COUNT = 10,
   parameter int unsigned GAP_TICKS  = 2
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       clk_enable,
   input  logic       conf_request,
   input  logic       column_ready,
   input  logic       position_sync_in,
   output logic       position_sync_out,
   output logic       new_configuration_ready,
   output logic       conf_busy,
   output logic [7:0] conf_count
);

   typedef enum logic [1:0] {IDLE, WAIT_SLOT, PUSH, GAP} state_t;

   localparam logic [7:0] PUSH_LAST = 8'(PUSH_COUNT);
   localparam logic [3:0] GAP_LAST  = 4'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
`ifdef DRV_CONF_AUTOBOOT_EN
   localparam logic PEND_RST = 1'b1;
`else
   localparam logic PEND_RST = 1'b0;
`endif

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [3:0] gap_q, gap_d;
   logic       ncr_q, ncr_d;
   logic       pend_q, pend_d;
   logic       col_q, col_d;
   logic       sync_q, sync_d;
   logic       sync_lat_q, sync_lat_d;
   logic [7:0] count_inc;
   logic       busy;

   assign busy      = (state_q != IDLE) | pend_q;
   assign count_inc = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      gap_d   = gap_q;
      ncr_d   = ncr_q;
      col_d   = 1'b0;
      pend_d  = pend_q | conf_request;
      case (state_q)
         IDLE: begin
            ncr_d = 1'b0;
            if (pend_q) begin
               state_d = WAIT_SLOT;
               count_d = 8'd0;
               pend_d  = conf_request;
            end
         end
         WAIT_SLOT: begin
            // A column boundary seen between ticks is held until the next enabled tick.
            if (clk_enable) begin
               if (col_q | column_ready) begin
                  state_d = PUSH;
                  ncr_d   = 1'b1;
                  count_d = count_inc;
               end
            end else begin
               col_d = col_q | column_ready;
            end
         end
         PUSH: begin
            if (clk_enable) begin
               if (count_q >= PUSH_LAST) begin
                  state_d = IDLE;
                  ncr_d   = 1'b0;
               end else if (GAP_TICKS == 0) begin
                  ncr_d   = 1'b1;
                  count_d = count_inc;
               end else begin
                  state_d = GAP;
                  ncr_d   = 1'b0;
                  gap_d   = 4'd0;
               end
            end
         end
         GAP: begin
            if (clk_enable) begin
               if (gap_q == GAP_LAST) begin
                  state_d = PUSH;
                  ncr_d   = 1'b1;
                  count_d = count_inc;
                  gap_d   = 4'd0;
               end else begin
                  gap_d = gap_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            ncr_d   = 1'b0;
         end
      endcase
   end

   // Syncs during busy (including one already in flight when busy rose) merge into one deferred pulse.
   always_comb begin
      sync_lat_d = busy ? (sync_lat_q | position_sync_in | sync_q) : 1'b0;
      sync_d     = ~busy & (position_sync_in | sync_lat_q);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         count_q    <= 8'd0;
         gap_q      <= 4'd0;
         ncr_q      <= 1'b0;
         pend_q     <= PEND_RST;
         col_q      <= 1'b0;
         sync_q     <= 1'b0;
         sync_lat_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         gap_q      <= gap_d;
         ncr_q      <= ncr_d;
         pend_q     <= pend_d;
         col_q      <= col_d;
         sync_q     <= sync_d;
         sync_lat_q <= sync_lat_d;
      end
   end

   assign new_configuration_ready = ncr_q;
   assign conf_busy               = busy;
   assign conf_count              = count_q;
   assign position_sync_out       = sync_q & ~busy;

endmodule

// File: tb/tb_drv_conf_sequencer.sv
// Directed bench for drv_conf_sequencer (default build): main instance 10 pulses / gap 2, second instance 3 pulses / gap 0.
module tb_drv_conf_sequencer;

   logic       clk = 1'b0;
   logic       nrst, clk_enable, conf_request, column_ready, position_sync_in, conf_request0;
   logic       position_sync_out, ncr, busy;
   logic [7:0] cnt;
   logic       psync0, ncr0, busy0;
   logic [7:0] cnt0;

   always #5 clk = ~clk;

   drv_conf_sequencer #(.PUSH_COUNT(10), .GAP_TICKS(2)) u_dut (
      .clk(clk), .nrst(nrst), .clk_enable(clk_enable), .conf_request(conf_request),
      .column_ready(column_ready), .position_sync_in(position_sync_in),
      .position_sync_out(position_sync_out), .new_configuration_ready(ncr),
      .conf_busy(busy), .conf_count(cnt));

   drv_conf_sequencer #(.PUSH_COUNT(3), .GAP_TICKS(0)) u_dut0 (
      .clk(clk), .nrst(nrst), .clk_enable(clk_enable), .conf_request(conf_request0),
      .column_ready(column_ready), .position_sync_in(position_sync_in),
      .position_sync_out(psync0), .new_configuration_ready(ncr0),
      .conf_busy(busy0), .conf_count(cnt0));

   int n_cmp = 0;
   int n_err = 0;

   bit req_s[0:1023], col_s[0:1023], sync_s[0:1023], en_s[0:1023], req0_s[0:1023];

   int ncr_high, busy_fall, busy_hi, out_cnt, out_last, out_busy, follow_err;
   int ncr0_high, ncr0_first, ncr0_last, busy0_fall;
   int rises[$];

   task automatic drive_idle;
      conf_request = 0; conf_request0 = 0; column_ready = 0; position_sync_in = 0; clk_enable = 1;
   endtask

   task automatic apply_reset;
      drive_idle();
      nrst = 0;
      repeat (2) @(posedge clk);
      #1 nrst = 1;
   endtask

   task automatic clear_sched;
      for (int i = 0; i < 1024; i++) begin
         req_s[i] = 0; col_s[i] = 0; sync_s[i] = 0; en_s[i] = 1; req0_s[i] = 0;
      end
   endtask

   // Drives the schedule cycle by cycle and records what the outputs did.
   task automatic run(input int n);
      logic ncr_p, busy_p, ncr0_p, busy0_p, in_p;
      ncr_high = 0; busy_fall = -1; busy_hi = 0; out_cnt = 0; out_last = -1; out_busy = 0;
      follow_err = 0; ncr0_high = 0; ncr0_first = -1; ncr0_last = -1; busy0_fall = -1;
      rises.delete();
      ncr_p = ncr; busy_p = busy; ncr0_p = ncr0; busy0_p = busy0; in_p = position_sync_in;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         conf_request = req_s[c]; conf_request0 = req0_s[c]; column_ready = col_s[c];
         position_sync_in = sync_s[c]; clk_enable = en_s[c];
         @(negedge clk);
         if (ncr) begin ncr_high++; if (!ncr_p) rises.push_back(c); end
         if (busy) busy_hi++;
         if (busy_p && !busy) busy_fall = c;
         if (position_sync_out) begin out_cnt++; out_last = c; if (busy) out_busy++; end
         if (!busy && position_sync_out !== in_p) follow_err++;
         if (ncr0) begin ncr0_high++; if (ncr0_first < 0) ncr0_first = c; ncr0_last = c; end
         if (busy0_p && !busy0) busy0_fall = c;
         ncr_p = ncr; busy_p = busy; ncr0_p = ncr0; busy0_p = busy0; in_p = sync_s[c];
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_reset;
      drive_idle();
      nrst = 0;
      @(negedge clk);
      n_cmp++; if (ncr !== 1'b0) begin n_err++; $display("FAIL reset_ncr: got %b, expected 0", ncr); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      n_cmp++; if (cnt !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d, expected 0", cnt); end
      n_cmp++; if (position_sync_out !== 1'b0) begin n_err++; $display("FAIL reset_sync_out: got %b, expected 0", position_sync_out); end
      @(posedge clk); #1 nrst = 1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b, expected 0", busy); end
      $display("test_reset done");
   endtask

   task automatic test_idle;
      int exp_out;
      clear_sched();
      exp_out = 0;
      for (int c = 0; c < 1000; c++) begin
         sync_s[c] = 1'($urandom_range(0, 1));
         en_s[c]   = 1'($urandom_range(0, 1));
         if (c < 999 && sync_s[c]) exp_out++;
      end
      run(1000);
      n_cmp++; if (ncr_high !== 0) begin n_err++; $display("FAIL idle_ncr: got %0d high cycles, expected 0", ncr_high); end
      n_cmp++; if (busy_hi !== 0) begin n_err++; $display("FAIL idle_busy: got %0d busy cycles, expected 0", busy_hi); end
      n_cmp++; if (follow_err !== 0) begin n_err++; $display("FAIL idle_follow: got %0d late/wrong cycles, expected 0", follow_err); end
      n_cmp++; if (out_cnt !== exp_out) begin n_err++; $display("FAIL idle_sync_count: got %0d, expected %0d", out_cnt, exp_out); end
      $display("test_idle done: %0d sync cycles out", out_cnt);
   endtask

   task automatic test_sequence;
      clear_sched();
      req_s[0] = 1; col_s[5] = 1;
      run(60);
      n_cmp++; if (rises.size() !== 10) begin n_err++; $display("FAIL seq_pulses: got %0d, expected 10", rises.size()); end
      n_cmp++; if (ncr_high !== 10) begin n_err++; $display("FAIL seq_high_cycles: got %0d, expected 10", ncr_high); end
      if (rises.size() == 10) begin
         n_cmp++; if (rises[0] !== 6) begin n_err++; $display("FAIL seq_first: got %0d, expected 6", rises[0]); end
         for (int i = 1; i < 10; i++) begin
            n_cmp++;
            if (rises[i] - rises[i-1] !== 3) begin
               n_err++; $display("FAIL seq_spacing%0d: got %0d, expected 3", i, rises[i] - rises[i-1]);
            end
         end
      end
      n_cmp++; if (cnt !== 8'd10) begin n_err++; $display("FAIL seq_count: got %0d, expected 10", cnt); end
      n_cmp++; if (busy_fall !== 34) begin n_err++; $display("FAIL seq_busy_fall: got %0d, expected 34", busy_fall); end
      $display("test_sequence done: %0d pulses", rises.size());
   endtask

   task automatic test_merge;
      clear_sched();
      req_s[0] = 1; req_s[10] = 1; req_s[15] = 1; req_s[20] = 1;
      col_s[5] = 1; col_s[50] = 1; col_s[100] = 1;
      run(150);
      n_cmp++; if (rises.size() !== 20) begin n_err++; $display("FAIL merge_pulses: got %0d, expected 20", rises.size()); end
      if (rises.size() > 10) begin
         n_cmp++; if (rises[10] !== 51) begin n_err++; $display("FAIL merge_second_start: got %0d, expected 51", rises[10]); end
      end
      n_cmp++; if (cnt !== 8'd10) begin n_err++; $display("FAIL merge_count: got %0d, expected 10", cnt); end
      n_cmp++; if (busy_fall !== 79) begin n_err++; $display("FAIL merge_busy_fall: got %0d, expected 79", busy_fall); end
      $display("test_merge done: %0d pulses", rises.size());
   endtask

   task automatic test_final_push_request;
      clear_sched();
      req_s[0] = 1; req_s[33] = 1; col_s[5] = 1; col_s[50] = 1; col_s[100] = 1;
      run(150);
      n_cmp++; if (rises.size() !== 20) begin n_err++; $display("FAIL final_req_pulses: got %0d, expected 20", rises.size()); end
      n_cmp++; if (busy_fall !== 79) begin n_err++; $display("FAIL final_req_busy_fall: got %0d, expected 79", busy_fall); end
      $display("test_final_push_request done: %0d pulses", rises.size());
   endtask

   task automatic test_sync_gate(input int second_at);
      clear_sched();
      req_s[0] = 1; col_s[5] = 1; sync_s[10] = 1; sync_s[second_at] = 1;
      run(60);
      n_cmp++; if (out_busy !== 0) begin n_err++; $display("FAIL sync_busy_out_%0d: got %0d cycles, expected 0", second_at, out_busy); end
      n_cmp++; if (out_cnt !== 1) begin n_err++; $display("FAIL sync_pulses_%0d: got %0d, expected 1", second_at, out_cnt); end
      n_cmp++; if (out_last !== 35) begin n_err++; $display("FAIL sync_pulse_cycle_%0d: got %0d, expected 35", second_at, out_last); end
      $display("test_sync_gate(%0d) done: %0d pulses", second_at, out_cnt);
   endtask

   task automatic test_enable_latch;
      clear_sched();
      for (int c = 0; c < 100; c++) en_s[c] = (c % 2 == 0);
      req_s[0] = 1; col_s[7] = 1;
      run(100);
      n_cmp++; if (rises.size() !== 10) begin n_err++; $display("FAIL en_pulses: got %0d, expected 10", rises.size()); end
      n_cmp++; if (ncr_high !== 20) begin n_err++; $display("FAIL en_high_cycles: got %0d, expected 20", ncr_high); end
      if (rises.size() == 10) begin
         n_cmp++; if (rises[0] !== 9) begin n_err++; $display("FAIL en_first: got %0d, expected 9", rises[0]); end
         n_cmp++; if (rises[9] - rises[8] !== 6) begin n_err++; $display("FAIL en_spacing: got %0d, expected 6", rises[9] - rises[8]); end
      end
      n_cmp++; if (busy_fall !== 65) begin n_err++; $display("FAIL en_busy_fall: got %0d, expected 65", busy_fall); end
      $display("test_enable_latch done: %0d pulses", rises.size());
   endtask

   task automatic test_gap_zero;
      clear_sched();
      req0_s[0] = 1; col_s[5] = 1;
      run(30);
      n_cmp++; if (ncr0_high !== 3) begin n_err++; $display("FAIL gap0_high: got %0d, expected 3", ncr0_high); end
      n_cmp++; if (ncr0_first !== 6) begin n_err++; $display("FAIL gap0_first: got %0d, expected 6", ncr0_first); end
      n_cmp++; if (ncr0_last !== 8) begin n_err++; $display("FAIL gap0_last: got %0d, expected 8", ncr0_last); end
      n_cmp++; if (cnt0 !== 8'd3) begin n_err++; $display("FAIL gap0_count: got %0d, expected 3", cnt0); end
      n_cmp++; if (busy0_fall !== 9) begin n_err++; $display("FAIL gap0_busy_fall: got %0d, expected 9", busy0_fall); end
      $display("test_gap_zero done: %0d high cycles", ncr0_high);
   endtask

   task automatic test_reset_mid;
      clear_sched();
      req_s[0] = 1; col_s[5] = 1;
      run(15);
      n_cmp++; if (rises.size() !== 3) begin n_err++; $display("FAIL mid_pre_pulses: got %0d, expected 3", rises.size()); end
      #1;
      n_cmp++; if (ncr !== 1'b1 || cnt !== 8'd4) begin n_err++; $display("FAIL mid_fourth: got ncr=%b count=%0d, expected 1/4", ncr, cnt); end
      nrst = 0;
      #1;
      n_cmp++; if (ncr !== 1'b0) begin n_err++; $display("FAIL mid_async_ncr: got %b, expected 0", ncr); end
      n_cmp++; if (cnt !== 8'd0) begin n_err++; $display("FAIL mid_async_count: got %0d, expected 0", cnt); end
      n_cmp++; if (busy !== 1'b0 || position_sync_out !== 1'b0) begin n_err++; $display("FAIL mid_async_flags: got busy=%b sync=%b, expected 0/0", busy, position_sync_out); end
      repeat (2) @(posedge clk);
      #1 nrst = 1;
      clear_sched();
      col_s[10] = 1; col_s[40] = 1;
      run(80);
      n_cmp++; if (ncr_high !== 0) begin n_err++; $display("FAIL mid_after_release: got %0d high cycles, expected 0", ncr_high); end
      n_cmp++; if (busy_hi !== 0) begin n_err++; $display("FAIL mid_after_busy: got %0d busy cycles, expected 0", busy_hi); end
      clear_sched();
      req_s[0] = 1; col_s[5] = 1;
      run(40);
      n_cmp++; if (rises.size() !== 10) begin n_err++; $display("FAIL mid_restart_pulses: got %0d, expected 10", rises.size()); end
      $display("test_reset_mid done");
   endtask

   initial begin
      nrst = 1;
      drive_idle();
      test_reset();
      test_idle();
      apply_reset(); test_sequence();
      apply_reset(); test_merge();
      apply_reset(); test_final_push_request();
      apply_reset(); test_sync_gate(20);
      apply_reset(); test_sync_gate(34);
      apply_reset(); test_enable_latch();
      apply_reset(); test_gap_zero();
      apply_reset(); test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/drv_conf_sequencer.md
DRV_CONF_SEQUENCER -- requirements
Module: drv_conf_sequencer

Interface
REQ-001 SHALL have parameter PUSH_COUNT, default 10, number of configuration pulses per sequence (1..255).
REQ-002 SHALL have parameter GAP_TICKS, default 2, idle enabled ticks between consecutive pulses (0..15).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clk_enable  input  1  tick qualifier; state advances only on cycles with clk_enable=1.
REQ-006 SHALL have port conf_request  input  1  one-clk strobe requesting a configuration sequence.
REQ-007 SHALL have port column_ready  input  1  one-clk pulse from driver controller marking a column boundary.
REQ-008 SHALL have port position_sync_in  input  1  one-clk position strobe from hall sensor path.
REQ-009 SHALL have port position_sync_out  output  1  gated position strobe to framebuffer and driver controller.
REQ-010 SHALL have port new_configuration_ready  output  1  configuration push strobe to driver controller.
REQ-011 SHALL have port conf_busy  output  1  high while a sequence is pending or running.
REQ-012 SHALL have port conf_count  output  8  pulses issued in the current or last sequence.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_SLOT, PUSH, GAP.
REQ-014 IDLE -> WAIT_SLOT on the first clk cycle where start_pending=1; conf_count cleared on that transition.
REQ-015 WAIT_SLOT -> PUSH on the first enabled tick at or after a column_ready pulse; column_ready seen while clk_enable=0 is latched until the next enabled tick.
REQ-016 PUSH SHALL assert new_configuration_ready for exactly one enabled-tick period (registered on the enabled tick, cleared on the next enabled tick) and increment conf_count.
REQ-017 PUSH -> GAP if conf_count < PUSH_COUNT and GAP_TICKS > 0; PUSH -> PUSH if GAP_TICKS = 0; PUSH -> IDLE when conf_count reaches PUSH_COUNT.
REQ-018 GAP SHALL count GAP_TICKS enabled ticks with new_configuration_ready=0, then return to PUSH.
REQ-019 conf_count SHALL saturate at 255 and never wrap.
REQ-020 start_pending SHALL be set by conf_request in any state and cleared on the IDLE->WAIT_SLOT transition; multiple requests during a sequence SHALL merge into exactly one follow-up sequence.
REQ-021 conf_request coincident with the final PUSH SHALL produce one follow-up sequence.
REQ-022 conf_busy = (state != IDLE) or start_pending, combinational from registers.
REQ-023 While conf_busy=0, position_sync_out SHALL equal position_sync_in delayed by one clk.
REQ-024 While conf_busy=1, position_sync_out SHALL be 0; a position_sync_in during busy SHALL be latched (one deep, extras merged) and emitted as a single one-clk pulse on the clk after conf_busy falls.
REQ-025 position_sync_in arriving on the same clk that conf_busy falls SHALL produce exactly one pulse, not two.

Reset
REQ-026 On nrst low, state=IDLE, new_configuration_ready=0, position_sync_out=0, conf_count=0, gap counter=0, column and sync latches cleared, immediately and asynchronously.
REQ-027 Reset mid-sequence SHALL abort without further pulses; the start_pending value after release is defined only by REQ-028.

Configuration
REQ-028 Macro DRV_CONF_AUTOBOOT_EN defined: start_pending SHALL be 1 after reset release, so one full sequence runs at boot without conf_request. Undefined: start_pending resets to 0 and sequences start only from conf_request.

Verification
REQ-029 AUTOBOOT defined, PUSH_COUNT=10, GAP_TICKS=2, column_ready after 5 ticks -> 10 pulses spaced 3 ticks apart, conf_count=10, conf_busy falls after the 10th pulse.
REQ-030 AUTOBOOT undefined, no conf_request for 1000 clks -> new_configuration_ready stays 0, conf_busy=0, position_sync_out follows input with 1-clk delay.
REQ-031 Three conf_request strobes during a running sequence -> exactly two sequences total (20 pulses), conf_count=10 at the end.
REQ-032 Two position_sync_in pulses during busy -> position_sync_out=0 throughout, then exactly one pulse on the clk after conf_busy falls.
REQ-033 GAP_TICKS=0, PUSH_COUNT=3 -> new_configuration_ready high for 3 consecutive enabled-tick periods.
REQ-034 nrst asserted after the 4th pulse -> outputs 0 immediately; without the macro no pulses after release until conf_request.
